ederah_result_framer: RTL and testbench

Output framing stage between the ERBIUM engine results stream and the QDMA C2H AXI4-Stream. Buffers result beats in a small FIFO, drives `tkeep`, counts data beats per frame, and optionally appends a trailer beat (magic, NFA hash, beat count, frame sequence) so the host can validate each result frame. Fully back-pressure aware on both sides.

---
 rtl/ederah_result_framer.sv | 163 ++++++++++++++++
 tb/tb_ederah_result_framer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ederah_result_framer.sv
// ederah_result_framer: FIFO-buffered framer from engine results to C2H stream.
// Trailer beat (magic, hash, count, seq) enabled by ERBIUM_RESULT_TRAILER_EN.
module ederah_result_framer #(
  parameter int C_TDATA_WIDTH = 512,
  parameter int C_FIFO_DEPTH  = 16
) (
  input  logic                       data_clk,
  input  logic                       data_rst_n,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [C_TDATA_WIDTH-1:0]   s_tdata,
  input  logic                       s_tlast,
  input  logic [31:0]                nfa_hash_i,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [C_TDATA_WIDTH-1:0]   m_tdata,
  output logic [C_TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                       m_tlast,
  output logic                       frame_done_o,
  output logic [15:0]                frame_seq_o
);
  localparam int W  = C_TDATA_WIDTH;
  localparam int KW = W / 8;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(C_FIFO_DEPTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
`ifdef ERBIUM_RESULT_TRAILER_EN
  localparam logic [1:0] TRAILER = 2'd2;
  localparam logic [1:0] END_ST  = TRAILER;
`else
  localparam logic [1:0] END_ST  = IDLE;
`endif

  logic [W:0]    mem [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [W:0]    head;
  logic          s_fire, m_fire, fifo_empty, out_free;
  logic          pop_ok, pop, fifo_rd, fifo_wr;

  assign s_tready   = count < DEPTH;
  assign s_fire     = s_tvalid & s_tready;
  assign m_fire     = m_tvalid & m_tready;
  assign fifo_empty = count == '0;
  assign out_free   = ~m_tvalid | m_tready;
  // An empty FIFO lets the incoming beat bypass straight to the output
  assign head       = fifo_empty ? {s_tdata, s_tlast} : mem[rd_ptr];
  assign pop        = pop_ok & out_free & (~fifo_empty | s_fire);
  assign fifo_rd    = pop & ~fifo_empty;
  assign fifo_wr    = s_fire & ~(pop & fifo_empty);

`ifdef ERBIUM_RESULT_TRAILER_EN
  logic [31:0]   hash_q, beat_cnt;
  logic          trl_q, trl_load;
  logic [W-1:0]  trl_data;
  logic [KW-1:0] trl_keep;

  assign pop_ok       = state != TRAILER;
  assign trl_load     = (state == TRAILER) & ~trl_q & out_free;
  assign frame_done_o = m_fire & trl_q;

  always_comb begin
    trl_data         = '0;
    trl_data[31:0]   = 32'hE4BA_0001;
    trl_data[63:32]  = hash_q;
    trl_data[95:64]  = beat_cnt;
    trl_data[111:96] = frame_seq_o;
    trl_keep         = '0;
    trl_keep[15:0]   = '1;
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) trl_q <= 1'b0;
    else if (pop) trl_q <= 1'b0;
    else if (trl_load) trl_q <= 1'b1;
    else if (m_fire) trl_q <= 1'b0;
  end
`else
  logic unused_hash;
  assign unused_hash  = ^nfa_hash_i;
  assign pop_ok       = 1'b1;
  assign frame_done_o = m_fire & m_tlast;
`endif

  always_ff @(posedge data_clk) begin
    if (fifo_wr) mem[wr_ptr] <= {s_tdata, s_tlast};
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (pop) begin
      m_tvalid <= 1'b1;
      m_tdata  <= head[W:1];
      m_tkeep  <= '1;
`ifdef ERBIUM_RESULT_TRAILER_EN
      m_tlast  <= 1'b0;
    end else if (trl_load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= trl_data;
      m_tkeep  <= trl_keep;
      m_tlast  <= 1'b1;
`else
      m_tlast  <= head[0];
`endif
    end else if (m_fire) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      state       <= IDLE;
      frame_seq_o <= '0;
`ifdef ERBIUM_RESULT_TRAILER_EN
      hash_q      <= '0;
      beat_cnt    <= '0;
`endif
    end else begin
      if (frame_done_o) frame_seq_o <= frame_seq_o + 1'b1;
      unique case (state)
        IDLE: if (pop) begin
`ifdef ERBIUM_RESULT_TRAILER_EN
          hash_q   <= nfa_hash_i;
          beat_cnt <= 32'd1;
`endif
          state <= head[0] ? END_ST : STREAM;
        end
        STREAM: if (pop) begin
`ifdef ERBIUM_RESULT_TRAILER_EN
          if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
`endif
          if (head[0]) state <= END_ST;
        end
`ifdef ERBIUM_RESULT_TRAILER_EN
        TRAILER: if (trl_q & m_fire) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ederah_result_framer.sv
// tb_ederah_result_framer: directed bench with a frame-level output model.
// Works with ERBIUM_RESULT_TRAILER_EN defined or undefined.
module tb_ederah_result_framer;
  localparam int W  = 512;
  localparam int KW = W / 8;
`ifdef ERBIUM_RESULT_TRAILER_EN
  localparam int NT = 1;
`else
  localparam int NT = 0;
`endif

  logic          clk, rst_n;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  s_tdata;
  logic [31:0]   nfa;
  logic          m_tvalid, m_tready, m_tlast;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          frame_done;
  logic [15:0]   frame_seq;

  ederah_result_framer #(.C_TDATA_WIDTH(W), .C_FIFO_DEPTH(16)) dut (
    .data_clk(clk), .data_rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast),
    .nfa_hash_i(nfa),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .frame_done_o(frame_done), .frame_seq_o(frame_seq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int rmode = 0;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 2) m_tready = 1'($urandom_range(0, 1));
      else m_tready = (rmode == 0);
    end
  end

  typedef struct {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
    logic          fin;
  } beat_t;

  beat_t exp_q[$];
  beat_t e, o;
  int checks = 0, errors = 0;
  int done_cnt = 0, wr_frames = 0, fcnt = 0, obs = 0, s_acc = 0;
  int last_frame_out = 0, last_trl_cnt = -1, last_trl_seq = -1;
  logic [31:0] fhash;
  bit in_frame = 0, hold = 0;
  logic [W-1:0] hd;
  logic [KW-1:0] hk;
  logic hl;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model: every accepted input beat maps to one output beat, plus a trailer per frame
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      done_cnt = 0; wr_frames = 0; in_frame = 0; obs = 0; hold = 0;
    end else begin
      chk32("frame_seq", 32'(frame_seq), 32'(done_cnt[15:0]));
      if (hold) begin
        chk32("stall_valid", 32'(m_tvalid), 32'd1);
        chk("stall_data", m_tdata, hd);
        chk32("stall_keep", 32'(m_tkeep[31:0]), 32'(hk[31:0]));
        chk32("stall_last", 32'(m_tlast), 32'(hl));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat act=%0h exp=none", m_tdata);
        end else begin
          o = exp_q.pop_front();
          chk("out_data", m_tdata, o.d);
          chk("out_keep", W'(m_tkeep), W'(o.k));
          chk32("out_last", 32'(m_tlast), 32'(o.l));
          chk32("out_done", 32'(frame_done), 32'(o.fin));
          obs++;
          if (o.fin) begin
            done_cnt++;
            last_frame_out = obs;
            obs = 0;
            last_trl_cnt = int'(m_tdata[95:64]);
            last_trl_seq = int'(m_tdata[111:96]);
          end
        end
      end else begin
        chk32("done_idle", 32'(frame_done), 32'd0);
      end
      if (s_tvalid && s_tready) begin
        s_acc++;
        if (!in_frame) begin
          fhash = nfa; fcnt = 0; in_frame = 1;
        end
        fcnt++;
        e.d = s_tdata;
        e.k = '1;
`ifdef ERBIUM_RESULT_TRAILER_EN
        e.l = 1'b0; e.fin = 1'b0;
`else
        e.l = s_tlast; e.fin = s_tlast;
`endif
        exp_q.push_back(e);
        if (s_tlast) begin
          in_frame = 0;
`ifdef ERBIUM_RESULT_TRAILER_EN
          e.d = '0;
          e.d[31:0] = 32'hE4BA_0001;
          e.d[63:32] = fhash;
          e.d[95:64] = 32'(fcnt);
          e.d[111:96] = wr_frames[15:0];
          e.k = '0;
          e.k[15:0] = '1;
          e.l = 1'b1; e.fin = 1'b1;
          exp_q.push_back(e);
`endif
          wr_frames++;
        end
      end
      hold = m_tvalid && !m_tready;
      hd = m_tdata; hk = m_tkeep; hl = m_tlast;
    end
  end

  task automatic rand_data(output logic [W-1:0] d);
    for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = $urandom;
  endtask

  task automatic send_beats(int n, bit last_at_end, bit rnd);
    for (int b = 0; b < n; b++) begin
      bit ok;
      int t;
      if (rnd && $urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      rand_data(s_tdata);
      s_tlast = last_at_end && (b == n - 1);
      t = 0;
      do begin
        @(negedge clk); ok = s_tready;
        @(posedge clk); #1; t++;
      end while (!ok && t < 3000);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL send_timeout act=stalled exp=accepted");
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 5000) begin
      @(posedge clk); t++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || m_tvalid) begin
      errors++;
      $display("FAIL drain_timeout act=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk32("rst_s_tready", 32'(s_tready), 32'd1);
    chk32("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_m_tkeep", W'(m_tkeep), '0);
    chk32("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk32("rst_done", 32'(frame_done), 32'd0);
    chk32("rst_seq", 32'(frame_seq), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] d1;
  bit tx_done;

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    nfa = 32'h1234_5678;
    do_reset();

    // Single-beat frame: latency and trailer layout pinned by literals
    rand_data(d1);
    s_tvalid = 1'b1; s_tdata = d1; s_tlast = 1'b1;
    @(negedge clk);
    chk32("t2_ready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    chk32("t2_lat_valid", 32'(m_tvalid), 32'd1);
    chk("t2_data", m_tdata, d1);
`ifdef ERBIUM_RESULT_TRAILER_EN
    chk32("t2_data_last", 32'(m_tlast), 32'd0);
    @(negedge clk);
    chk32("t2_trl_valid", 32'(m_tvalid), 32'd1);
    chk32("t2_magic", m_tdata[31:0], 32'hE4BA_0001);
    chk32("t2_hash", m_tdata[63:32], 32'h1234_5678);
    chk32("t2_cnt", m_tdata[95:64], 32'd1);
    chk32("t2_tseq", 32'(m_tdata[111:96]), 32'd0);
    chk32("t2_keep", m_tkeep[31:0], 32'h0000_FFFF);
    chk32("t2_trl_last", 32'(m_tlast), 32'd1);
    chk32("t2_done", 32'(frame_done), 32'd1);
`else
    chk32("t2_last", 32'(m_tlast), 32'd1);
    chk32("t2_done", 32'(frame_done), 32'd1);
`endif
    @(negedge clk);
    chk32("t2_seq", 32'(frame_seq), 32'd1);
    drain();

    // 40-beat frame against a stalled sink: 16 in FIFO plus 1 in output
    nfa = 32'hA5A5_0F0F;
    rmode = 1;
    @(posedge clk); #2;
    s_acc = 0; tx_done = 0;
    fork
      begin send_beats(40, 1'b1, 1'b0); tx_done = 1; end
    join_none
    repeat (30) @(posedge clk);
    #2;
    chk32("t3_accepted", 32'(s_acc), 32'd17);
    chk32("t3_ready_low", 32'(s_tready), 32'd0);
    rmode = 0;
    for (int t = 0; t < 5000 && !tx_done; t++) @(posedge clk);
    drain();
    chk32("t3_frame_beats", 32'(last_frame_out), 32'(40 + NT));
`ifdef ERBIUM_RESULT_TRAILER_EN
    chk32("t3_trl_cnt", 32'(last_trl_cnt), 32'd40);
`endif

    // 100 frames, 1..20 beats, random gaps and back-pressure
    do_reset();
    nfa = 32'hCAFE_F00D;
    rmode = 2;
    for (int f = 0; f < 100; f++) send_beats($urandom_range(1, 20), 1'b1, 1'b1);
    rmode = 0;
    drain();
    chk32("t4_seq", 32'(frame_seq), 32'd100);
`ifdef ERBIUM_RESULT_TRAILER_EN
    chk32("t4_last_tseq", 32'(last_trl_seq), 32'd99);
`endif

    // Back-to-back frames: second frame arrives while first trailer is pending
    do_reset();
    nfa = 32'h0BAD_F00D;
    send_beats(2, 1'b1, 1'b0);
    send_beats(2, 1'b1, 1'b0);
    drain();
    chk32("t5_seq", 32'(frame_seq), 32'd2);
    chk32("t5_frame_beats", 32'(last_frame_out), 32'(2 + NT));
`ifdef ERBIUM_RESULT_TRAILER_EN
    chk32("t5_tseq", 32'(last_trl_seq), 32'd1);
`endif

    // Reset mid-frame discards the partial frame
    nfa = 32'h7777_1111;
    rmode = 1;
    @(posedge clk); #2;
    send_beats(5, 1'b0, 1'b0);
    do_reset();
    rmode = 0;
    send_beats(3, 1'b1, 1'b0);
    drain();
    chk32("t6_seq", 32'(frame_seq), 32'd1);
    chk32("t6_frame_beats", 32'(last_frame_out), 32'(3 + NT));
`ifdef ERBIUM_RESULT_TRAILER_EN
    chk32("t6_trl_cnt", 32'(last_trl_cnt), 32'd3);
    chk32("t6_tseq", 32'(last_trl_seq), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
